// File: rtl/wb_spi_pkg.sv
// Shared definitions for the Wishbone SPI master: register offsets, bit indices, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wb_spi_pkg;

  // Register offsets, decoded from wb_adr_i[3:2]
  localparam logic [1:0] SPI_RXTX   = 2'd0;
  localparam logic [1:0] SPI_STATUS = 2'd1;
  localparam logic [1:0] SPI_DIV    = 2'd2;
  localparam logic [1:0] SPI_CTRL   = 2'd3;

  // STATUS / CONTROL bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int CTRL_IEN  = 8;

  // Transfer engine states: LOW/HIGH are the two SCLK half-periods
  typedef enum logic [1:0] {
    XFER_IDLE = 2'd0,
    XFER_LOW  = 2'd1,
    XFER_HIGH = 2'd2
  } xfer_state_t;

endpackage

// File: rtl/wb_spi_xfer.sv
// SPI mode-0 byte engine: divider, 8-bit MSB-first shift, one-cycle done pulse.
// Latency: 16*(div+1) clk from the start edge to the edge where busy falls.
// Backpressure: start is ignored while busy; the caller must gate it.
// Ports: start/tx_byte/div in; miso sampled on SCLK rise; busy, done_pulse,
//        rx_byte, sclk, mosi out.
module wb_spi_xfer
  import wb_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  tx_byte,
  input  logic [15:0] div,
  input  logic        miso,
  output logic        busy,
  output logic        done_pulse,
  output logic [7:0]  rx_byte,
  output logic        sclk,
  output logic        mosi
);

  xfer_state_t state_q, state_d;
  logic [15:0] div_active_q, div_active_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= XFER_IDLE;
      div_active_q <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      rx_byte_q    <= '0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_active_q <= div_active_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      rx_byte_q    <= rx_byte_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_active_d = div_active_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rx_byte_d    = rx_byte_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    done_pulse   = 1'b0;
    case (state_q)
      XFER_IDLE: begin
        if (start) begin
          // Divider is snapshotted so DIVISOR writes mid-transfer only affect the next byte
          tx_d         = tx_byte;
          mosi_d       = tx_byte[7];
          div_active_d = div;
          div_cnt_d    = div;
          bit_cnt_d    = '0;
          state_d      = XFER_LOW;
        end
      end
      XFER_LOW: begin
        if (div_cnt_q == 16'd0) begin
          sclk_d    = 1'b1;
          rx_d      = {rx_q[6:0], miso};
          div_cnt_d = div_active_q;
          state_d   = XFER_HIGH;
        end else begin
          div_cnt_d = div_cnt_q - 16'd1;
        end
      end
      XFER_HIGH: begin
        if (div_cnt_q == 16'd0) begin
          sclk_d    = 1'b0;
          div_cnt_d = div_active_q;
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d  = rx_q;
            done_pulse = 1'b1;
            state_d    = XFER_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = {tx_q[6:0], 1'b0};
            mosi_d    = tx_q[6];
            state_d   = XFER_LOW;
          end
        end else begin
          div_cnt_d = div_cnt_q - 16'd1;
        end
      end
      default: state_d = XFER_IDLE;
    endcase
  end

  assign busy    = (state_q != XFER_IDLE);
  assign rx_byte = rx_byte_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: rtl/wb_spi.sv
// Wishbone slave SPI master: register decode, DONE/IEN, interrupt, chip selects.
// Latency: ack and read data one clk after stb&cyc; writes take effect on the ack edge.
// Backpressure: none on the bus (every access acked); RXTX writes while busy are dropped.
// Ports: clk, reset (async, active low), wb_* slave bus, intr, spi_sclk/mosi/miso/cs_n.
module wb_spi
  import wb_spi_pkg::*;
#(
  parameter logic [15:0] default_div = 16'd49,
  parameter int          cs_width    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                intr,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [cs_width-1:0] spi_cs_n
);

  logic                ack_q;
  logic [31:0]         dat_q;
  logic [15:0]         div_q;
  logic                ien_q;
  logic [cs_width-1:0] cs_n_q;
  logic                done_q;
  logic                intr_q;

  logic        access, wr_en, rd_en, start, done_clr;
  logic        busy, done_pulse;
  logic [7:0]  rx_byte;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;
  logic        unused_ok;

  // ~ack_q makes a held strobe produce ack every other cycle
  assign access  = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr_en   = access & wb_we_i;
  assign rd_en   = access & ~wb_we_i;
  assign reg_sel = wb_adr_i[3:2];
  assign start   = wr_en & (reg_sel == SPI_RXTX) & ~busy;
  assign done_clr = (rd_en & (reg_sel == SPI_RXTX)) |
                    (wr_en & (reg_sel == SPI_STATUS) & wb_dat_i[STAT_DONE]);

  assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i};

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      SPI_RXTX:   rd_data[7:0] = rx_byte;
      SPI_STATUS: begin
        rd_data[STAT_DONE] = done_q;
        rd_data[STAT_BUSY] = busy;
      end
      SPI_DIV:    rd_data[15:0] = div_q;
      SPI_CTRL:   begin
        rd_data[cs_width-1:0] = cs_n_q;
        rd_data[CTRL_IEN]     = ien_q;
      end
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      div_q  <= default_div;
      ien_q  <= 1'b0;
      cs_n_q <= '1;
      done_q <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      ack_q <= access;
      dat_q <= rd_en ? rd_data : 32'd0;
      if (wr_en && (reg_sel == SPI_DIV)) div_q <= wb_dat_i[15:0];
      if (wr_en && (reg_sel == SPI_CTRL)) begin
        cs_n_q <= wb_dat_i[cs_width-1:0];
        ien_q  <= wb_dat_i[CTRL_IEN];
      end
      // start beats a clear; completion beats a clear on the same edge
      if (start)           done_q <= 1'b0;
      else if (done_pulse) done_q <= 1'b1;
      else if (done_clr)   done_q <= 1'b0;
      intr_q <= done_q & ien_q;
    end
  end

  wb_spi_xfer u_xfer (
    .clk        (clk),
    .rst_n      (reset),
    .start      (start),
    .tx_byte    (wb_dat_i[7:0]),
    .div        (div_q),
    .miso       (spi_miso),
    .busy       (busy),
    .done_pulse (done_pulse),
    .rx_byte    (rx_byte),
    .sclk       (spi_sclk),
    .mosi       (spi_mosi)
  );

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = intr_q;
  assign spi_cs_n = cs_n_q;

endmodule
